// File: rtl/axil_write_arbiter.sv
// Per-slave AXI-Lite write-path arbiter: grants one master for the whole AW/W/B transaction.
// Define AXIL_WRITE_ARB_RR_EN to build round-robin arbitration instead of fixed priority.
module axil_write_arbiter #(
   parameter int NUMBER_MASTER = 20,
   parameter int IDX_WIDTH     = $clog2(NUMBER_MASTER)
) (
   input  logic                     aclk,
   input  logic                     areset,
   input  logic [NUMBER_MASTER-1:0] req,
   input  logic                     aw_hs,
   input  logic                     w_hs,
   input  logic                     b_hs,
   output logic [NUMBER_MASTER-1:0] grant,
   output logic [IDX_WIDTH-1:0]     grant_idx,
   output logic                     grant_valid,
   output logic                     protocol_err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t                   state_q, state_d;
   logic                     aw_done_q, aw_done_d;
   logic                     w_done_q, w_done_d;
   logic [NUMBER_MASTER-1:0] grant_q, grant_d;
   logic [IDX_WIDTH-1:0]     grant_idx_q, grant_idx_d;
   logic                     grant_valid_q, grant_valid_d;
   logic                     protocol_err_q, protocol_err_d;

   logic                     winner_found;
   logic [IDX_WIDTH-1:0]     winner_idx;

`ifdef AXIL_WRITE_ARB_RR_EN
   logic [IDX_WIDTH-1:0]     last_idx_q, last_idx_d;
   logic [IDX_WIDTH-1:0]     candidate;

   // Scan upward from the master after the last one served, wrapping around.
   always_comb begin
      winner_found = 1'b0;
      winner_idx   = '0;
      candidate    = '0;
      for (int i = 1; i <= NUMBER_MASTER; i++) begin
         candidate = IDX_WIDTH'((32'(last_idx_q) + 32'(i)) % 32'(NUMBER_MASTER));
         if (!winner_found && req[candidate]) begin
            winner_found = 1'b1;
            winner_idx   = candidate;
         end
      end
   end
`else
   // NOTE: every variable written here gets a default first, so no latch is inferred.
   always_comb begin
      winner_found = 1'b0;
      winner_idx   = '0;
      for (int i = NUMBER_MASTER - 1; i >= 0; i--) begin
         if (req[i]) begin
            winner_found = 1'b1;
            winner_idx   = IDX_WIDTH'(i);
         end
      end
   end
`endif

   always_comb begin
      state_d        = state_q;
      aw_done_d      = aw_done_q;
      w_done_d       = w_done_q;
      grant_d        = grant_q;
      grant_idx_d    = grant_idx_q;
      grant_valid_d  = grant_valid_q;
      protocol_err_d = protocol_err_q | (b_hs && (state_q != RESP));
`ifdef AXIL_WRITE_ARB_RR_EN
      last_idx_d     = last_idx_q;
`endif

      case (state_q)
         IDLE: begin
            if (winner_found) begin
               grant_d             = '0;
               grant_d[winner_idx] = 1'b1;
               grant_idx_d         = winner_idx;
               grant_valid_d       = 1'b1;
               state_d             = DATA;
`ifdef AXIL_WRITE_ARB_RR_EN
               last_idx_d          = winner_idx;
`endif
            end
         end
         DATA: begin
            // AW and W may complete in either order or together.
            if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = RESP;
            end else begin
               aw_done_d = aw_done_q | aw_hs;
               w_done_d  = w_done_q | w_hs;
            end
         end
         RESP: begin
            if (b_hs) begin
               grant_d       = '0;
               grant_idx_d   = '0;
               grant_valid_d = 1'b0;
               state_d       = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q        <= IDLE;
         aw_done_q      <= 1'b0;
         w_done_q       <= 1'b0;
         grant_q        <= '0;
         grant_idx_q    <= '0;
         grant_valid_q  <= 1'b0;
         protocol_err_q <= 1'b0;
`ifdef AXIL_WRITE_ARB_RR_EN
         last_idx_q     <= IDX_WIDTH'(NUMBER_MASTER - 1);
`endif
      end else begin
         state_q        <= state_d;
         aw_done_q      <= aw_done_d;
         w_done_q       <= w_done_d;
         grant_q        <= grant_d;
         grant_idx_q    <= grant_idx_d;
         grant_valid_q  <= grant_valid_d;
         protocol_err_q <= protocol_err_d;
`ifdef AXIL_WRITE_ARB_RR_EN
         last_idx_q     <= last_idx_d;
`endif
      end
   end

   assign grant        = grant_q;
   assign grant_idx    = grant_idx_q;
   assign grant_valid  = grant_valid_q;
   assign protocol_err = protocol_err_q;

endmodule

// File: tb/tb_axil_write_arbiter.sv
// Directed bench for axil_write_arbiter with four masters; expectations follow the
// AXIL_WRITE_ARB_RR_EN setting of the build.
module tb_axil_write_arbiter;

   localparam int NM = 4;
   localparam int IW = $clog2(NM);

   logic          aclk = 1'b0;
   logic          areset;
   logic [NM-1:0] req;
   logic          aw_hs, w_hs, b_hs;
   logic [NM-1:0] grant;
   logic [IW-1:0] grant_idx;
   logic          grant_valid;
   logic          protocol_err;

   int checks = 0;
   int errors = 0;

   axil_write_arbiter #(.NUMBER_MASTER(NM)) dut (
      .aclk         (aclk),
      .areset       (areset),
      .req          (req),
      .aw_hs        (aw_hs),
      .w_hs         (w_hs),
      .b_hs         (b_hs),
      .grant        (grant),
      .grant_idx    (grant_idx),
      .grant_valid  (grant_valid),
      .protocol_err (protocol_err)
   );

   always #5 aclk = ~aclk;

   // Outputs are sampled 1ns after the edge; inputs are also changed there.
   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, ".grant"}, 32'(grant), 32'h0);
      check({tag, ".idx"},   32'(grant_idx), 32'h0);
      check({tag, ".valid"}, 32'(grant_valid), 32'h0);
   endtask

   task automatic check_grant(input string tag, input logic [NM-1:0] g, input logic [IW-1:0] idx);
      check({tag, ".grant"}, 32'(grant), 32'(g));
      check({tag, ".idx"},   32'(grant_idx), 32'(idx));
      check({tag, ".valid"}, 32'(grant_valid), 32'h1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [IW-1:0] rr_exp [5];
`ifdef AXIL_WRITE_ARB_RR_EN
      rr_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`else
      rr_exp = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`endif

      areset = 1'b1;
      req    = 4'b1111;
      aw_hs  = 1'b0;
      w_hs   = 1'b0;
      b_hs   = 1'b0;

      // Reset held two cycles with every master requesting.
      tick();
      check_idle("rst0");
      check("rst0.perr", 32'(protocol_err), 32'h0);
      tick();
      check_idle("rst1");
      areset = 1'b0;
      tick();
      check_grant("first", 4'b0001, 2'd0);

      // AW and W in the same cycle, then B.
      aw_hs = 1'b1; w_hs = 1'b1; req = 4'b0000;
      tick();
      aw_hs = 1'b0; w_hs = 1'b0;
      check_grant("same_cyc.resp", 4'b0001, 2'd0);
      b_hs = 1'b1;
      tick();
      b_hs = 1'b0;
      check_idle("same_cyc.rel");
      check("same_cyc.perr", 32'(protocol_err), 32'h0);

      // req=0110: master 1 granted, held through separated AW/W/B handshakes.
      req = 4'b0110;
      tick();
      check_grant("t2.c1", 4'b0010, 2'd1);
      tick();
      check_grant("t2.c2", 4'b0010, 2'd1);
      aw_hs = 1'b1; req = 4'b0100;
      tick();
      aw_hs = 1'b0;
      check_grant("t2.c3", 4'b0010, 2'd1);
      tick();
      check_grant("t2.c4", 4'b0010, 2'd1);
      w_hs = 1'b1;
      tick();
      w_hs = 1'b0;
      check_grant("t2.c5", 4'b0010, 2'd1);
      tick();
      tick();
      check_grant("t2.c7", 4'b0010, 2'd1);
      b_hs = 1'b1;
      tick();
      b_hs = 1'b0;
      check_idle("t2.bubble");
      tick();
      check_grant("t2.next", 4'b0100, 2'd2);
      check("t2.perr", 32'(protocol_err), 32'h0);

      // Granted master 2 drops req while master 0 rises: grant is locked.
      req = 4'b0001;
      tick();
      check_grant("t4.lock", 4'b0100, 2'd2);
      aw_hs = 1'b1; w_hs = 1'b1;
      tick();
      aw_hs = 1'b0; w_hs = 1'b0;
      check_grant("t4.resp", 4'b0100, 2'd2);
      b_hs = 1'b1;
      tick();
      b_hs = 1'b0;
      check_idle("t4.bubble");
      tick();
      check_grant("t4.next", 4'b0001, 2'd0);

      // b_hs in DATA: sticky protocol_err, state stays DATA (AW still outstanding).
      req = 4'b0000;
      b_hs = 1'b1;
      tick();
      b_hs = 1'b0;
      check("t5.perr_set", 32'(protocol_err), 32'h1);
      check_grant("t5.held", 4'b0001, 2'd0);
      w_hs = 1'b1;
      tick();
      w_hs = 1'b0;
      check_grant("t5.w_only", 4'b0001, 2'd0);
      w_hs = 1'b1;
      tick();
      w_hs = 1'b0;
      check_grant("t5.w_again", 4'b0001, 2'd0);
      aw_hs = 1'b1;
      tick();
      aw_hs = 1'b0;
      check_grant("t5.resp", 4'b0001, 2'd0);
      b_hs = 1'b1;
      tick();
      b_hs = 1'b0;
      check_idle("t5.rel");
      check("t5.perr_sticky", 32'(protocol_err), 32'h1);
      areset = 1'b1;
      tick();
      areset = 1'b0;
      check("t5.perr_clr", 32'(protocol_err), 32'h0);

      // Four masters requesting continuously for five transactions.
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         tick();
         check($sformatf("t6.idx%0d", k), 32'(grant_idx), 32'(rr_exp[k]));
         check($sformatf("t6.onehot%0d", k), 32'(grant), 32'(4'b0001 << rr_exp[k]));
         aw_hs = 1'b1; w_hs = 1'b1;
         tick();
         aw_hs = 1'b0; w_hs = 1'b0;
         b_hs = 1'b1;
         tick();
         b_hs = 1'b0;
         check($sformatf("t6.bubble%0d", k), 32'(grant_valid), 32'h0);
      end

      // Reset in the middle of DATA aborts the transaction.
      tick();
      check("abort.pre", 32'(grant_valid), 32'h1);
      aw_hs = 1'b1;
      tick();
      aw_hs = 1'b0;
      areset = 1'b1; req = 4'b0000;
      tick();
      areset = 1'b0;
      check_idle("abort.rst");
      w_hs = 1'b1;
      tick();
      w_hs = 1'b0;
      check_idle("abort.idle");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
